fifo_rd_ctrl_read: RTL
======================

// Module: fifo_rd_ctrl_read
// PURPOSE
// - Read-domain controller of the bridge read-path async FIFO. Owns the read pointer and the empty flag.
// - Synchronises the write-domain gray pointer, drives r_addr into fifo_mem_read and registers
//   r_data into a valid/ready output stage for the read-domain AHB logic.
// - Returns its gray read pointer to the write domain for full detection.
// PARAMETERS
// - D_SIZE      16  data width
// - F_DEPTH     4   FIFO depth in words, power of two
// - P_SIZE      3   pointer width = log2(F_DEPTH)+1 (the extra MSB is the wrap bit)
// - SYNC_STAGES 2   flop stages on w_gray_ptr, minimum 2
// PORTS
// - r_clk       in   1            read-domain clock
// - r_rstn      in   1            reset r_rstn, asynchronous, active-low; clock r_clk
// - w_gray_ptr  in   P_SIZE       write gray pointer from the write domain, unsynchronised
// - mem_rdata   in   D_SIZE       r_data from fifo_mem_read, combinational on r_addr
// - r_addr      out  P_SIZE-1     memory read address = rbin[P_SIZE-2:0]
// - r_gray_ptr  out  P_SIZE       registered gray read pointer, to the write-domain synchroniser
// - r_empty     out  1            registered FIFO-empty flag
// - rd_valid    out  1            rd_data holds a word
// - rd_ready    in   1            consumer accepts the word when rd_valid && rd_ready
// - rd_data     out  D_SIZE       output data register
// BEHAVIOUR
// - Reset: rbin=0, r_gray_ptr=0, synchroniser flops=0, r_empty=1, rd_valid=0, rd_data=0, r_addr=0.
// - Sync: wq = w_gray_ptr after SYNC_STAGES r_clk flops. This is the only logic that samples w_gray_ptr.
// - load = !rd_valid || rd_ready
// - fire = load && !r_empty
// - rbin_next = rbin + fire
// - rgray_next = (rbin_next>>1) ^ rbin_next
// - Every edge: rbin<=rbin_next; r_gray_ptr<=rgray_next; r_empty<=(rgray_next==wq).
// - Output stage: if fire, rd_data<=mem_rdata and rd_valid<=1. Else if rd_ready, rd_valid<=0. Else hold.
// - rd_data is stable while rd_valid && !rd_ready. No word is dropped or duplicated.
// - Throughput: one word per cycle while rd_ready=1 and the FIFO is non-empty.
// - Latency (SYNC_STAGES=2): w_gray_ptr changes before edge t -> wq updates at edge t+1
//   -> r_empty falls after edge t+2 -> rd_valid rises after edge t+3.
// - Empty: no fire, so rbin and r_addr hold. A registered word may still drain from the output stage.
// - Wrap-around: rbin wraps modulo 2^P_SIZE. Gray coding changes one bit per increment.
//   Empty compares all P_SIZE bits, so full and empty are not aliased.
// - Simultaneous write-pointer update and last read: r_empty is computed from rgray_next,
//   so the flag is correct on the cycle the last word fires.
// - Reset mid-transfer: the in-flight word is discarded. The write domain must be reset in the same window.
// - Memory ordering: the integrator ensures a word is visible on mem_rdata no later than its
//   pointer arrives on wq. The fifo_mem_read copy adds 1 stage, and SYNC_STAGES>=2 covers it.
// CONFIGURATION
// - FIFO_RD_LEVEL_EN defined:
//   - adds output port r_level [P_SIZE-1:0]
//   - r_level is registered and equals gray2bin(wq) - rbin_next, modulo 2^P_SIZE
//   - r_level resets to 0 and reads F_DEPTH when a full FIFO is seen
// - FIFO_RD_LEVEL_EN undefined: r_level port and its logic are absent; all other behaviour is identical.
// TESTING
// - T1 Reset: assert r_rstn=0 mid-run -> r_empty=1, rd_valid=0, r_gray_ptr=000, r_addr=00, rd_data=0.
// - T2 Single word: w_gray_ptr 000->001, mem[0]=16'hA5A5, rd_ready=1
//   -> rd_valid=1 with rd_data=A5A5 after 4 edges; r_gray_ptr=001; r_empty=1.
// - T3 Fill and drain: w_gray_ptr=110 (4 words 1..4), rd_ready=1
//   -> rd_data 1,2,3,4 on consecutive cycles; r_addr 0,1,2,3; r_empty rises with the 4th fire.
// - T4 Backpressure: rd_ready=0 for 5 cycles with 3 words queued
//   -> rd_data holds word 1 and rbin advances only once.
//   Release -> words 2,3 follow with no loss or repeat.
// - T5 Wrap: stream 20 words through the depth-4 FIFO
//   -> r_gray_ptr cycles 000,001,011,010,110,111,101,100,000; data order preserved.
// - T6 Level (FIFO_RD_LEVEL_EN): 3 words written, rd_ready=0
//   -> r_level=3 before the first fire, then 2 after it while word 1 is held in rd_data.

Source files
------------

// File: rtl/fifo_rd_ctrl_read.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_read
// Read-domain controller of the bridge read-path async FIFO.
//  - Synchronises the write-side gray pointer into r_clk.
//  - Owns the binary/gray read pointer and the registered empty flag.
//  - Drives the memory read address and captures mem_rdata into a
//    valid/ready output register for the read-domain AHB logic.
//  - Returns the registered gray read pointer to the write domain.
// Optional feature macro: FIFO_RD_LEVEL_EN adds the registered r_level port
// (words visible to the read side, seen through the synchroniser).
// -----------------------------------------------------------------------------
module fifo_rd_ctrl_read #(
   parameter int D_SIZE      = 16,
   parameter int F_DEPTH     = 4,
   parameter int P_SIZE      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic              r_clk,
   input  logic              r_rstn,
   input  logic [P_SIZE-1:0] w_gray_ptr,
   input  logic [D_SIZE-1:0] mem_rdata,
   output logic [P_SIZE-2:0] r_addr,
   output logic [P_SIZE-1:0] r_gray_ptr,
   output logic              r_empty,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [D_SIZE-1:0] rd_data
`ifdef FIFO_RD_LEVEL_EN
   ,
   output logic [P_SIZE-1:0] r_level
`endif
);

   localparam int A_SIZE = $clog2(F_DEPTH);

   logic [P_SIZE-1:0] r_sync [SYNC_STAGES];
   logic [P_SIZE-1:0] r_rbin;
   logic [P_SIZE-1:0] w_wq;
   logic              w_load;
   logic              w_fire;
   logic [P_SIZE-1:0] w_rbin_next;
   logic [P_SIZE-1:0] w_rgray_next;

   // Multi-flop synchroniser: the only logic that samples w_gray_ptr.
   // NOTE: every stage of this flop array is reset so the empty compare
   // starts from a known pointer; the array is tiny, so resetting it is free.
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= w_gray_ptr;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_wq = r_sync[SYNC_STAGES-1];

   // Pop decision and next read pointer; the output register can take a word
   // when it is empty or is being emptied this cycle.
   always_comb begin
      w_load       = !rd_valid || rd_ready;
      w_fire       = w_load && !r_empty;
      w_rbin_next  = r_rbin + {{(P_SIZE-1){1'b0}}, w_fire};
      w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;
   end

   // Read pointer, gray copy for the write domain, and empty flag. Empty is
   // judged on the next pointer so it is already correct on the last pop.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         r_rbin     <= '0;
         r_gray_ptr <= '0;
         r_empty    <= 1'b1;
      end else begin
         r_rbin     <= w_rbin_next;
         r_gray_ptr <= w_rgray_next;
         r_empty    <= (w_rgray_next == w_wq);
      end
   end

   assign r_addr = r_rbin[A_SIZE-1:0];

   // Output register: capture on pop, drop valid when consumed, else hold.
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (w_fire) begin
         rd_valid <= 1'b1;
         rd_data  <= mem_rdata;
      end else if (rd_ready) begin
         rd_valid <= 1'b0;
      end
   end

`ifdef FIFO_RD_LEVEL_EN
   logic [P_SIZE-1:0] w_wbin;

   function automatic logic [P_SIZE-1:0] gray2bin(input logic [P_SIZE-1:0] g);
      logic [P_SIZE-1:0] b;
      b[P_SIZE-1] = g[P_SIZE-1];
      for (int i = P_SIZE - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   assign w_wbin = gray2bin(w_wq);

   // Fill level as seen by the read side; the wrap bit lets a full FIFO
   // read as F_DEPTH rather than zero.
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         r_level <= '0;
      end else begin
         r_level <= w_wbin - w_rbin_next;
      end
   end
`endif

endmodule
